// File: rtl/uart_frame_shift_register_pkg.sv
// Shared UART constants, shift-register mode encodings and the frame-length helper.
// The transmitter, receiver and frame shift register all import this package.
package uart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Encodings for the shift_register_n mode port.
  // 01 is unused and behaves as hold.
  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_SHIFT = 2'b10,
    SR_LOAD  = 2'b11
  } sr_mode_e;

  function automatic int uart_frame_bits(input int data, input int par_en, input int stop);
    return 1 + data + par_en + stop;
  endfunction

endpackage

// File: rtl/uart_frame_shift_register_shift_reg.sv
// Generic right-shift register with hold/shift/load modes and a parameterised reset value.
// Serial data enters at the MSB; bit 0 is the first bit to leave.
module shift_register_n
  import uart_pkg::*;
#(
  parameter int               WIDTH = 11,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] reg_q;

  always_comb begin
    reg_d = reg_q;
    case (mode)
      SR_SHIFT: reg_d = {serial_in, reg_q[WIDTH-1:1]};
      SR_LOAD:  reg_d = parallel_in;
      default:  reg_d = reg_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_q <= INIT;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign parallel_out = reg_q;

endmodule

// File: rtl/uart_frame_shift_register.sv
// UART frame shift register: builds TX frames, captures RX frames, counts shifts and
// checks parity/framing of the current contents. Controllers only sequence load/shift.
module uart_frame_shift_register
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  localparam int FRAME_BITS = uart_frame_bits(DATA_BITS, PARITY_EN, STOP_BITS),
  localparam int CW         = $clog2(FRAME_BITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_BITS-1:0]  data_in_p,
  input  logic                  data_in_s,
  output logic                  serial_out,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic [DATA_BITS-1:0]  data_out,
  output logic [CW-1:0]         bit_count,
  output logic                  frame_full,
  output logic                  parity_error,
  output logic                  framing_error
);

  localparam logic          PAR_SEL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FRAME_BITS);
  localparam int            PAR_POS   = DATA_BITS + 1;
  localparam int            STOP_LSB  = FRAME_BITS - STOP_BITS;

  logic [FRAME_BITS-1:0] frame_load;
  logic [FRAME_BITS-1:0] frame_q;
  logic [1:0]            sr_mode;
  logic                  tx_parity;
  logic [CW-1:0]         cnt_d;
  logic [CW-1:0]         cnt_q;
  logic [STOP_BITS-1:0]  stop_field;

  // Even parity XORs the data; odd parity inverts that.
  assign tx_parity = (^data_in_p) ^ PAR_SEL;

  always_comb begin
    frame_load = {FRAME_BITS{IDLE_LEVEL}};
    frame_load[0] = START_BIT;
    frame_load[DATA_BITS:1] = data_in_p;
    if (PARITY_EN != 0) begin
      frame_load[PAR_POS] = tx_parity;
    end
    for (int i = STOP_LSB; i < FRAME_BITS; i++) begin
      frame_load[i] = STOP_BIT;
    end
  end

  // Load beats shift beats hold.
  always_comb begin
    sr_mode = SR_HOLD;
    if (load) begin
      sr_mode = SR_LOAD;
    end else if (shift) begin
      sr_mode = SR_SHIFT;
    end
  end

  shift_register_n #(
    .WIDTH (FRAME_BITS),
    .INIT  ({FRAME_BITS{IDLE_LEVEL}})
  ) u_shift_reg (
    .clock        (clock),
    .reset        (reset),
    .mode         (sr_mode),
    .serial_in    (data_in_s),
    .parallel_in  (frame_load),
    .parallel_out (frame_q)
  );

  // Count saturates so frame_full stays high if the controller keeps shifting.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (shift && (cnt_q != FULL_CNT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stop_field = frame_q[FRAME_BITS-1:STOP_LSB];

  generate
    if (PARITY_EN != 0) begin : g_parity
      assign parity_error = ((^{frame_q[DATA_BITS:1], frame_q[PAR_POS]}) != PAR_SEL);
    end else begin : g_no_parity
      assign parity_error = 1'b0;
    end
  endgenerate

  assign framing_error = (frame_q[0] != START_BIT) ||
                         (stop_field != {STOP_BITS{STOP_BIT}});

  assign serial_out = frame_q[0];
  assign frame_out  = frame_q;
  assign data_out   = frame_q[DATA_BITS:1];
  assign bit_count  = cnt_q;
  assign frame_full = (cnt_q == FULL_CNT);

endmodule

// File: tb/tb_uart_frame_shift_register.sv
// Self-checking bench for uart_frame_shift_register (8 data bits, even parity, 1 stop bit).
// Reference model keeps the line contents as a queue of bits, index 0 = next bit out.
module tb_uart_frame_shift_register;

  localparam int DB = 8;
  localparam int PE = 1;
  localparam int PO = 0;
  localparam int SB = 1;
  localparam int FB = 11;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          shift = 1'b0;
  logic [DB-1:0] data_in_p = '0;
  logic          data_in_s = 1'b1;
  logic          serial_out;
  logic [FB-1:0] frame_out;
  logic [DB-1:0] data_out;
  logic [CW-1:0] bit_count;
  logic          frame_full;
  logic          parity_error;
  logic          framing_error;

  int checks = 0;
  int errors = 0;

  bit line_q[$];
  int m_cnt;

  uart_frame_shift_register #(
    .DATA_BITS  (DB),
    .PARITY_EN  (PE),
    .PARITY_ODD (PO),
    .STOP_BITS  (SB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .shift         (shift),
    .data_in_p     (data_in_p),
    .data_in_s     (data_in_s),
    .serial_out    (serial_out),
    .frame_out     (frame_out),
    .data_out      (data_out),
    .bit_count     (bit_count),
    .frame_full    (frame_full),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic void m_reset();
    line_q.delete();
    for (int i = 0; i < FB; i++) line_q.push_back(1'b1);
    m_cnt = 0;
  endfunction

  function automatic void m_load(input logic [DB-1:0] d);
    int ones;
    ones = $countones(d);
    line_q.delete();
    line_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) line_q.push_back(d[i]);
    if (PE != 0) line_q.push_back(((ones + PO) % 2) == 1);
    for (int i = 0; i < SB; i++) line_q.push_back(1'b1);
    m_cnt = 0;
  endfunction

  function automatic void m_shift(input logic s);
    void'(line_q.pop_front());
    line_q.push_back(s);
    if (m_cnt < FB) m_cnt++;
  endfunction

  function automatic logic [FB-1:0] m_frame();
    logic [FB-1:0] v;
    v = '0;
    for (int i = 0; i < FB; i++) v[i] = line_q[i];
    return v;
  endfunction

  function automatic logic [DB-1:0] m_data();
    logic [DB-1:0] v;
    for (int i = 0; i < DB; i++) v[i] = line_q[i+1];
    return v;
  endfunction

  function automatic logic m_par_err();
    int ones;
    if (PE == 0) return 1'b0;
    ones = 0;
    for (int i = 1; i <= DB + 1; i++) ones += int'(line_q[i]);
    return (ones % 2) != PO;
  endfunction

  function automatic logic m_frm_err();
    logic e;
    e = (line_q[0] != 1'b0);
    for (int i = FB - SB; i < FB; i++) if (line_q[i] != 1'b1) e = 1'b1;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic l, input logic s, input logic sin, input logic [DB-1:0] d);
    load = l;
    shift = s;
    data_in_s = sin;
    data_in_p = d;
    if (l) m_load(d);
    else if (s) m_shift(sin);
    tick();
    load = 1'b0;
    shift = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    load = 1'b0;
    shift = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic shift_in_frame(input logic [FB-1:0] f);
    for (int i = 0; i < FB; i++) drive(1'b0, 1'b1, f[i], '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(2);
    checks++;
    if (frame_out !== 11'h7FF) begin
      errors++; $display("FAIL reset_frame got %h exp %h", frame_out, 11'h7FF);
    end
    checks++;
    if (serial_out !== 1'b1) begin
      errors++; $display("FAIL reset_serial got %b exp 1", serial_out);
    end
    checks++;
    if (bit_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", bit_count);
    end
    checks++;
    if (frame_full !== 1'b0) begin
      errors++; $display("FAIL reset_full got %b exp 0", frame_full);
    end
    checks++;
    if (framing_error !== 1'b1) begin
      errors++; $display("FAIL reset_framing got %b exp 1", framing_error);
    end
  endtask

  task automatic test_transmit();
    int exp_ser [FB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    drive(1'b1, 1'b0, 1'b1, 8'hA5);
    checks++;
    if (frame_out !== 11'h54A) begin
      errors++; $display("FAIL tx_load_frame got %h exp 54a", frame_out);
    end
    checks++;
    if (data_out !== 8'hA5 || bit_count !== 4'd0) begin
      errors++; $display("FAIL tx_load_data got %h/%0d exp a5/0", data_out, bit_count);
    end
    for (int i = 0; i < FB; i++) begin
      checks++;
      if (serial_out !== exp_ser[i][0]) begin
        errors++; $display("FAIL tx_serial_bit%0d got %b exp %0d", i, serial_out, exp_ser[i]);
      end
      drive(1'b0, 1'b1, 1'b1, '0);
    end
    checks++;
    if (frame_out !== 11'h7FF || frame_full !== 1'b1) begin
      errors++; $display("FAIL tx_done got %h full %b exp 7ff full 1", frame_out, frame_full);
    end
  endtask

  task automatic test_rx_clean();
    do_reset(1);
    for (int i = 0; i < FB; i++) begin
      checks++;
      if (frame_full !== 1'b0) begin
        errors++; $display("FAIL rx_early_full shift%0d got 1 exp 0", i);
      end
      drive(1'b0, 1'b1, 11'h54A >> i, '0);
    end
    checks++;
    if (frame_full !== 1'b1 || data_out !== 8'hA5) begin
      errors++; $display("FAIL rx_clean got full %b data %h exp 1 a5", frame_full, data_out);
    end
    checks++;
    if (parity_error !== 1'b0 || framing_error !== 1'b0) begin
      errors++; $display("FAIL rx_clean_flags got par %b frm %b exp 0 0", parity_error, framing_error);
    end
  endtask

  task automatic test_rx_errors();
    do_reset(1);
    shift_in_frame(11'h54A ^ 11'h200);
    checks++;
    if (frame_full !== 1'b1 || parity_error !== 1'b1 || framing_error !== 1'b0) begin
      errors++; $display("FAIL rx_bad_parity got full %b par %b frm %b exp 1 1 0",
                         frame_full, parity_error, framing_error);
    end
    do_reset(1);
    shift_in_frame(11'h54A & 11'h3FF);
    checks++;
    if (frame_full !== 1'b1 || parity_error !== 1'b0 || framing_error !== 1'b1) begin
      errors++; $display("FAIL rx_bad_stop got full %b par %b frm %b exp 1 0 1",
                         frame_full, parity_error, framing_error);
    end
    do_reset(1);
    shift_in_frame(11'h54A | 11'h001);
    checks++;
    if (framing_error !== 1'b1) begin
      errors++; $display("FAIL rx_bad_start got %b exp 1", framing_error);
    end
  endtask

  task automatic test_collision();
    logic [DB-1:0] d;
    do_reset(1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), '0);
    d = 8'($urandom);
    drive(1'b1, 1'b1, 1'b0, d);
    checks++;
    if (bit_count !== 4'd0 || frame_out !== m_frame()) begin
      errors++; $display("FAIL collision_load got %h/%0d exp %h/0", frame_out, bit_count, m_frame());
    end
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), '0);
      checks++;
      if (bit_count !== 4'((i > FB) ? FB : i) || frame_full !== (i >= FB)) begin
        errors++; $display("FAIL collision_sat shift%0d got %0d full %b exp %0d", i,
                           bit_count, frame_full, (i > FB) ? FB : i);
      end
      checks++;
      if (frame_out !== m_frame()) begin
        errors++; $display("FAIL collision_frame shift%0d got %h exp %h", i, frame_out, m_frame());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, '0);
    do_reset(1);
    checks++;
    if (frame_out !== 11'h7FF || bit_count !== 4'd0 || frame_full !== 1'b0) begin
      errors++; $display("FAIL reset_mid got %h/%0d/%b exp 7ff/0/0", frame_out, bit_count, frame_full);
    end
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        do_reset(1);
      end else begin
        drive(op == 1 || op == 2, op >= 2 && op <= 7, 1'($urandom_range(0, 1)), 8'($urandom));
      end
      checks++;
      if (frame_out !== m_frame() || serial_out !== line_q[0] || data_out !== m_data()) begin
        errors++; $display("FAIL rand_frame n%0d got %h exp %h", n, frame_out, m_frame());
      end
      checks++;
      if (bit_count !== m_cnt[CW-1:0] || frame_full !== (m_cnt == FB)) begin
        errors++; $display("FAIL rand_count n%0d got %0d/%b exp %0d", n, bit_count, frame_full, m_cnt);
      end
      checks++;
      if (parity_error !== m_par_err() || framing_error !== m_frm_err()) begin
        errors++; $display("FAIL rand_flags n%0d got %b%b exp %b%b", n,
                           parity_error, framing_error, m_par_err(), m_frm_err());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_reset();
    test_reset();
    test_transmit();
    test_rx_clean();
    test_rx_errors();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
